rom_dl_sequencer: RTL and testbench

ROM_DL_SEQUENCER -- requirements
Module: rom_dl_sequencer

---
 rtl/rom_dl_pkg.sv | 28 ++
 rtl/rom_dl_decode.sv | 31 +++
 rtl/rom_dl_sequencer.sv | 154 +++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// Shared definitions for the ROM download sequencer: region map, FSM states, error bits.
package rom_dl_pkg;

    localparam int unsigned NumRegions = 4;

    // Region indices double as bit positions in the one-hot write strobe.
    localparam int unsigned RegCpu   = 0;
    localparam int unsigned RegSound = 1;
    localparam int unsigned RegGfx   = 2;
    localparam int unsigned RegProm  = 3;

    localparam int unsigned RegionBase [NumRegions] = '{32'h0000, 32'h4000, 32'h4800, 32'h5000};
    localparam int unsigned RegionSize [NumRegions] = '{32'h4000, 32'h0800, 32'h0800, 32'h0020};

    // Sticky error flag positions.
    localparam int unsigned ErrW   = 2;
    localparam int unsigned ErrMap = 0;
    localparam int unsigned ErrOvr = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StPostRst,
        StRun
    } state_e;

endpackage

// File: rtl/rom_dl_decode.sv
// Combinational download-address decoder: region one-hot, region-relative offset, valid.
module rom_dl_decode
    import rom_dl_pkg::*;
#(
    parameter int unsigned AW = 16
) (
    input  logic [AW-1:0]         dl_addr,
    output logic [NumRegions-1:0] region,
    output logic [AW-1:0]         offset,
    output logic                  valid
);

    logic [31:0] addr_ext;

    // Regions do not overlap, so the first hit is the only hit.
    always_comb begin
        region   = '0;
        offset   = '0;
        valid    = 1'b0;
        addr_ext = 32'(dl_addr);
        for (int i = 0; i < NumRegions; i++) begin
            if (!valid && addr_ext >= RegionBase[i] &&
                addr_ext < RegionBase[i] + RegionSize[i]) begin
                region[i] = 1'b1;
                offset    = AW'(addr_ext - RegionBase[i]);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: routes hps_io download bytes to memory regions, holds the
// game core in reset during and after the download, and tracks checksum and errors.
module rom_dl_sequencer
    import rom_dl_pkg::*;
#(
    parameter int unsigned POST_RST_CYCLES = 1024,
    parameter int unsigned AW              = 16
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  dl_active,
    input  logic                  dl_wr,
    input  logic [AW-1:0]         dl_addr,
    input  logic [7:0]            dl_data,
    output logic                  dl_wait,
    input  logic                  reset_req,
    output logic [AW-1:0]         mem_addr,
    output logic [7:0]            mem_data,
    output logic [NumRegions-1:0] mem_we,
    input  logic                  mem_ready,
    output logic                  core_reset,
    output logic [15:0]           checksum,
    output logic [ErrW-1:0]       err
);

    localparam int unsigned CntW = (POST_RST_CYCLES > 1) ? $clog2(POST_RST_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(POST_RST_CYCLES - 1);

    state_e                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic [NumRegions-1:0] region_q, region_d;
    logic [15:0]           checksum_q, checksum_d;
    logic [ErrW-1:0]       err_q, err_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic [NumRegions-1:0] dec_region;
    logic [AW-1:0]         dec_offset;
    logic                  dec_valid;

    rom_dl_decode #(
        .AW (AW)
    ) u_decode (
        .dl_addr (dl_addr),
        .region  (dec_region),
        .offset  (dec_offset),
        .valid   (dec_valid)
    );

    // State and datapath registers; async reset clears everything including a pending write.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            region_q   <= '0;
            checksum_q <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            region_q   <= region_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic; the hold counter only runs in POST_RST and sits at zero elsewhere.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        region_d   = region_q;
        checksum_d = checksum_q;
        err_d      = err_q;
        cnt_d      = '0;

        case (state_q)
            StIdle: begin
                if (dl_active) begin
                    state_d    = StLoad;
                    checksum_d = '0;
                    err_d      = '0;
                end else begin
                    state_d = StPostRst;
                end
            end

            StLoad: begin
                if (!dl_active) begin
                    state_d = StPostRst;
                end else if (dl_wr) begin
                    if (dec_valid) begin
                        addr_d   = dec_offset;
                        data_d   = dl_data;
                        region_d = dec_region;
                        state_d  = StWrite;
                    end else begin
                        err_d[ErrMap] = 1'b1;
                    end
                end
            end

            StWrite: begin
                // Only one byte can be in flight; anything else is an overrun.
                if (dl_wr) begin
                    err_d[ErrOvr] = 1'b1;
                end
                if (mem_ready) begin
                    checksum_d = checksum_q + 16'(data_q);
                    state_d    = dl_active ? StLoad : StPostRst;
                end
            end

            StPostRst: begin
                if (reset_req) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StRun: begin
                // A new download takes priority over a reset request.
                if (dl_active) begin
                    state_d    = StLoad;
                    checksum_d = '0;
                    err_d      = '0;
                end else if (reset_req) begin
                    state_d = StPostRst;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only, so reset takes effect without a clock.
    always_comb begin
        dl_wait    = (state_q == StWrite);
        mem_we     = (state_q == StWrite) ? region_q : '0;
        core_reset = (state_q != StRun);
        mem_addr   = addr_q;
        mem_data   = data_q;
        checksum   = checksum_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed self-checking bench for rom_dl_sequencer with an 8-cycle post-reset hold.
module tb_rom_dl_sequencer;

    localparam int unsigned Hold = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        dl_active;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        reset_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [3:0]  mem_we;
    logic        mem_ready;
    logic        core_reset;
    logic [15:0] checksum;
    logic [1:0]  err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk_sys = ~clk_sys;

    rom_dl_sequencer #(
        .POST_RST_CYCLES (Hold),
        .AW              (16)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_wait    (dl_wait),
        .reset_req  (reset_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .core_reset (core_reset),
        .checksum   (checksum),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        reset_req = 1'b0;
        mem_ready = 1'b0;
        #3;
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_dl_wait", 32'(dl_wait), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step();
        reset_n = 1'b1;

        // Start a download: IDLE -> LOAD.
        dl_active = 1'b1;
        step();
        check("load_core_reset", 32'(core_reset), 32'd1);
        check("load_mem_we", 32'(mem_we), 32'd0);

        // Gfx byte, target ready immediately.
        dl_wr = 1'b1; dl_addr = 16'h4801; dl_data = 8'hA5; mem_ready = 1'b1;
        step();
        dl_wr = 1'b0;
        check("gfx_mem_we", 32'(mem_we), 32'h4);
        check("gfx_mem_addr", 32'(mem_addr), 32'h0001);
        check("gfx_mem_data", 32'(mem_data), 32'hA5);
        check("gfx_dl_wait", 32'(dl_wait), 32'd1);
        step();
        check("gfx_we_done", 32'(mem_we), 32'd0);
        check("gfx_checksum", 32'(checksum), 32'h00A5);

        // CPU byte with a 5-cycle stall.
        mem_ready = 1'b0;
        dl_wr = 1'b1; dl_addr = 16'h0010; dl_data = 8'h3C;
        step();
        dl_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_dl_wait", 32'(dl_wait), 32'd1);
            check("stall_mem_we", 32'(mem_we), 32'h1);
            check("stall_mem_addr", 32'(mem_addr), 32'h0010);
            check("stall_checksum", 32'(checksum), 32'h00A5);
            step();
        end
        mem_ready = 1'b1;
        step();
        check("stall_release_we", 32'(mem_we), 32'd0);
        check("stall_release_wait", 32'(dl_wait), 32'd0);
        check("stall_checksum_sum", 32'(checksum), 32'h00E1);

        // Out-of-map byte is dropped.
        dl_wr = 1'b1; dl_addr = 16'h6000; dl_data = 8'hFF;
        step();
        dl_wr = 1'b0;
        check("oom_mem_we", 32'(mem_we), 32'd0);
        check("oom_err", 32'(err), 32'h1);
        check("oom_checksum", 32'(checksum), 32'h00E1);
        step();
        check("oom_still_idle_we", 32'(mem_we), 32'd0);

        // End of download: exactly Hold cycles of core reset, then release.
        dl_active = 1'b0;
        step();
        check("post_entry_core_reset", 32'(core_reset), 32'd1);
        for (int i = 1; i < Hold; i++) begin
            step();
            check("post_hold_core_reset", 32'(core_reset), 32'd1);
        end
        step();
        check("post_run_core_reset", 32'(core_reset), 32'd0);
        check("post_run_checksum", 32'(checksum), 32'h00E1);

        // Reset request from RUN: another Hold-cycle pulse.
        reset_req = 1'b1;
        step();
        reset_req = 1'b0;
        check("rreq_entry_core_reset", 32'(core_reset), 32'd1);
        for (int i = 1; i < Hold; i++) begin
            step();
            check("rreq_hold_core_reset", 32'(core_reset), 32'd1);
        end
        step();
        check("rreq_run_core_reset", 32'(core_reset), 32'd0);

        // Reset request mid-hold restarts the count.
        reset_req = 1'b1;
        step();
        reset_req = 1'b0;
        step(); step(); step();
        reset_req = 1'b1;
        step();
        reset_req = 1'b0;
        for (int i = 1; i < Hold; i++) begin
            step();
            check("reload_hold_core_reset", 32'(core_reset), 32'd1);
        end
        step();
        check("reload_run_core_reset", 32'(core_reset), 32'd0);

        // Download and reset request together in RUN: download wins, flags cleared.
        dl_active = 1'b1; reset_req = 1'b1;
        step();
        reset_req = 1'b0;
        check("both_core_reset", 32'(core_reset), 32'd1);
        check("both_checksum_clr", 32'(checksum), 32'd0);
        check("both_err_clr", 32'(err), 32'd0);

        // PROM byte stalls; a second strobe during the stall is an overrun.
        mem_ready = 1'b0;
        dl_wr = 1'b1; dl_addr = 16'h5003; dl_data = 8'h11;
        step();
        check("prom_mem_we", 32'(mem_we), 32'h8);
        check("prom_mem_addr", 32'(mem_addr), 32'h0003);
        dl_addr = 16'h0020; dl_data = 8'h22;
        step();
        dl_wr = 1'b0;
        check("ovr_err", 32'(err), 32'h2);
        check("ovr_mem_addr", 32'(mem_addr), 32'h0003);
        check("ovr_mem_data", 32'(mem_data), 32'h11);
        mem_ready = 1'b1;
        step();
        check("ovr_checksum", 32'(checksum), 32'h0011);
        check("ovr_mem_we_done", 32'(mem_we), 32'd0);

        // dl_active drops during a stalled write: the write still completes.
        mem_ready = 1'b0;
        dl_wr = 1'b1; dl_addr = 16'h4000; dl_data = 8'h07;
        step();
        dl_wr = 1'b0;
        dl_active = 1'b0;
        step();
        check("drop_wr_wait", 32'(dl_wait), 32'd1);
        check("drop_wr_mem_we", 32'(mem_we), 32'h2);
        mem_ready = 1'b1;
        step();
        check("drop_wr_checksum", 32'(checksum), 32'h0018);
        check("drop_wr_done_we", 32'(mem_we), 32'd0);
        check("drop_wr_core_reset", 32'(core_reset), 32'd1);
        for (int i = 1; i < Hold; i++) step();
        step();
        check("drop_wr_run", 32'(core_reset), 32'd0);

        // Async reset in the middle of a stalled write.
        dl_active = 1'b1;
        step();
        mem_ready = 1'b0;
        dl_wr = 1'b1; dl_addr = 16'h1234; dl_data = 8'h5A;
        step();
        dl_wr = 1'b0;
        check("pre_arst_mem_we", 32'(mem_we), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_core_reset", 32'(core_reset), 32'd1);
        check("arst_dl_wait", 32'(dl_wait), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_mem_data", 32'(mem_data), 32'd0);
        check("arst_checksum", 32'(checksum), 32'd0);
        check("arst_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
